// File: rtl/issue_mul_fu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : issue_mul_fu_pkg
// Purpose  : Shared issue-lane types for the multiply functional unit.
// Revision : 1.0 - initial release
// ============================================================================
package issue_mul_fu_pkg;

    localparam int c_xlen_w    = 32;
    localparam int c_phy_reg_w = 6;

    typedef logic [c_xlen_w-1:0]    xlen_t;
    typedef logic [c_phy_reg_w-1:0] phy_reg_t;
    typedef logic                   bool;
    typedef logic [1:0]             aux_t;

    typedef enum logic [2:0] {
        FUN_ALU = 3'd0,
        FUN_MUL = 3'd1,
        FUN_DIV = 3'd2,
        FUN_LSU = 3'd3,
        FUN_BR  = 3'd4
    } fun_t;

    // Encoding matches aux[1:0] of the issue bundle.
    typedef enum logic [1:0] {
        MUL_LO = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_var_t;

    function automatic logic rs1_is_signed(input mul_var_t v);
        return (v == MULH) || (v == MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input mul_var_t v);
        return (v == MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_mul_fu_mul_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_step
// Purpose  : One radix-2^BITS_PER_CYCLE iteration of the unsigned multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mul_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int CNT_W          = 3
) (
    input  logic [2*XLEN-1:0]         i_acc,
    input  logic [XLEN-1:0]           i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_slice,
    input  logic [CNT_W-1:0]          i_cnt,
    output logic [2*XLEN-1:0]         o_acc_next
);

    logic [XLEN+BITS_PER_CYCLE-1:0] w_pp;
    logic [2*XLEN-1:0]              w_pp_ext;

    always_comb begin
        w_pp       = {{BITS_PER_CYCLE{1'b0}}, i_mcand} * {{XLEN{1'b0}}, i_slice};
        w_pp_ext   = {{(XLEN-BITS_PER_CYCLE){1'b0}}, w_pp};
        o_acc_next = i_acc + (w_pp_ext << (i_cnt * BITS_PER_CYCLE));
    end

endmodule
`default_nettype wire

// File: rtl/issue_mul_fu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : issue_mul_fu
// Purpose  : Iterative RV32M/RV64M multiply unit on one issue lane; holds the
//            result until the CDB grants it. ISSUE_MUL_FU_EARLY_AVAIL_EN lets a
//            new op be accepted in the same cycle the result is granted.
// Revision : 1.0 - initial release
// ============================================================================
module issue_mul_fu
    import issue_mul_fu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic                 avail,
    input  logic                 valid,
    input  fun_t                 fun,
    input  aux_t                 aux,
    input  logic [1:0][XLEN-1:0] ops,
    input  phy_reg_t             dst,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output phy_reg_t             cdb_dst,
    output logic [XLEN-1:0]      cdb_value
);

    localparam int c_n     = XLEN / BITS_PER_CYCLE;
    localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic                r_neg;
    mul_var_t            r_var;
    logic                r_cdb_valid;
    phy_reg_t            r_cdb_dst;
    logic [XLEN-1:0]     r_cdb_value;

    mul_var_t            w_var;
    logic                w_neg1;
    logic                w_neg2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_avail;
    logic                w_accept;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_final;
    logic [XLEN-1:0]     w_result;

    // Magnitude of the most-negative operand is exact as an unsigned XLEN value.
    always_comb begin
        w_var  = mul_var_t'(aux);
        w_neg1 = rs1_is_signed(w_var) & ops[0][XLEN-1];
        w_neg2 = rs2_is_signed(w_var) & ops[1][XLEN-1];
        w_mag1 = w_neg1 ? (~ops[0] + 1'b1) : ops[0];
        w_mag2 = w_neg2 ? (~ops[1] + 1'b1) : ops[1];
    end

`ifdef ISSUE_MUL_FU_EARLY_AVAIL_EN
    assign w_avail = (r_state == c_st_idle) ||
                     ((r_state == c_st_done) && cdb_ready && !flush);
`else
    assign w_avail = (r_state == c_st_idle);
`endif

    assign w_accept = valid && w_avail && (fun == FUN_MUL) && !flush;

    mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CNT_W          (c_cnt_w)
    ) u_mul_step (
        .i_acc      (r_acc),
        .i_mcand    (r_mcand),
        .i_slice    (r_mplier[BITS_PER_CYCLE-1:0]),
        .i_cnt      (r_cnt),
        .o_acc_next (w_acc_next)
    );

    // Sign fix-up and half select are folded into the last BUSY cycle so the
    // DONE outputs come straight from registers.
    always_comb begin
        w_final  = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
        w_result = (r_var == MUL_LO) ? w_final[XLEN-1:0] : w_final[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_var       <= MUL_LO;
            r_cdb_valid <= 1'b0;
            r_cdb_dst   <= '0;
            r_cdb_value <= '0;
        end else begin
            case (r_state)
                c_st_busy: begin
                    if (flush) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state     <= c_st_done;
                            r_cdb_valid <= 1'b1;
                            r_cdb_value <= w_result;
                        end
                    end
                end
                c_st_done: begin
                    if (cdb_ready || flush) begin
                        r_state     <= c_st_idle;
                        r_cdb_valid <= 1'b0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // Accept overrides the state-specific updates above.
            if (w_accept) begin
                r_state   <= c_st_busy;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_mcand   <= w_mag1;
                r_mplier  <= w_mag2;
                r_neg     <= w_neg1 ^ w_neg2;
                r_var     <= w_var;
                r_cdb_dst <= dst;
            end
        end
    end

    assign avail     = w_avail;
    assign cdb_valid = r_cdb_valid;
    assign cdb_dst   = r_cdb_dst;
    assign cdb_value = r_cdb_value;

endmodule
`default_nettype wire

// File: tb/tb_issue_mul_fu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_issue_mul_fu
// Purpose  : Scoreboard bench for issue_mul_fu against a 64-bit arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_mul_fu;
    import issue_mul_fu_pkg::*;

    localparam int XLEN = 32;
    localparam int BPC  = 4;
    localparam int N    = XLEN / BPC;
`ifdef ISSUE_MUL_FU_EARLY_AVAIL_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 avail;
    logic                 valid;
    fun_t                 fun;
    aux_t                 aux;
    logic [1:0][XLEN-1:0] ops;
    phy_reg_t             dst;
    logic                 cdb_valid;
    logic                 cdb_ready;
    phy_reg_t             cdb_dst;
    logic [XLEN-1:0]      cdb_value;

    issue_mul_fu #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .avail     (avail),
        .valid     (valid),
        .fun       (fun),
        .aux       (aux),
        .ops       (ops),
        .dst       (dst),
        .cdb_valid (cdb_valid),
        .cdb_ready (cdb_ready),
        .cdb_dst   (cdb_dst),
        .cdb_value (cdb_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  dst;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rdy_mode = 0;   // 0: tied high, 1: random, 2: held low

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width product by plain 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'h0, b});
        logic [63:0] p;
        case (v)
            2'b00:   p = {32'h0, a} * {32'h0, b};
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = {32'h0, a} * {32'h0, b};
        endcase
        return (v == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    initial begin
        cdb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       cdb_ready = 1'b1;
                1:       cdb_ready = 1'($urandom_range(0, 1));
                default: cdb_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency on first presentation, stability while held, value on grant.
    initial begin
        logic        prev_valid = 1'b0;
        logic        prev_hs    = 1'b0;
        logic [5:0]  prev_dst   = '0;
        logic [31:0] prev_val   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end else begin
                if (cdb_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_cdb_valid", 64'(cdb_valid), 64'(0));
                    end else begin
                        if (!prev_valid || prev_hs)
                            check("latency", 64'(cyc), 64'(sb_q[0].cyc + N + 1));
                        else begin
                            check("hold_dst", 64'(cdb_dst), 64'(prev_dst));
                            check("hold_value", 64'(cdb_value), 64'(prev_val));
                        end
                        if (cdb_ready) begin
                            check("cdb_dst", 64'(cdb_dst), 64'(sb_q[0].dst));
                            check("cdb_value", 64'(cdb_value), 64'(sb_q[0].val));
                            void'(sb_q.pop_front());
                        end
                    end
                end
                prev_valid = cdb_valid;
                prev_hs    = cdb_valid && cdb_ready;
                prev_dst   = cdb_dst;
                prev_val   = cdb_value;
            end
        end
    end

    // Holds valid until avail is seen; returns the accept cycle (-1 on timeout).
    task automatic issue(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] d, input bit expect_result, output int acc_cyc);
        int waited = 0;
        exp_t e;
        @(posedge clk);
        #1;
        valid  = 1'b1;
        fun    = FUN_MUL;
        aux    = v;
        ops[0] = a;
        ops[1] = b;
        dst    = d;
        @(negedge clk);
        while (!avail && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        acc_cyc = -1;
        if (!avail) begin
            check("issue_timeout", 64'(avail), 64'(1));
        end else begin
            acc_cyc = cyc;
            if (expect_result) begin
                e.dst = d;
                e.val = ref_mul(v, a, b);
                e.cyc = cyc;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb_q.size() != 0 || cdb_valid) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, w;
        logic [31:0] a, b;
        rst_n  = 1'b0;
        flush  = 1'b0;
        valid  = 1'b0;
        fun    = FUN_ALU;
        aux    = '0;
        ops    = '0;
        dst    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_avail", 64'(avail), 64'(1));
        check("reset_cdb_valid", 64'(cdb_valid), 64'(0));
        check("reset_cdb_dst", 64'(cdb_dst), 64'(0));
        check("reset_cdb_value", 64'(cdb_value), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First op: latency and avail profile.
        rdy_mode = 0;
        issue(2'b00, 32'd7, 32'hFFFFFFFD, 6'd5, 1'b1, t1);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            check("avail_busy", 64'(avail), 64'(0));
        end
        @(negedge clk);
        check("avail_done", 64'(avail), 64'(EARLY));
        drain();

        // Sign corner cases, issued back to back.
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd10, 1'b1, t1);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 1'b1, t2);
        check("b2b_spacing", 64'(t2 - t1), 64'(EARLY ? N + 1 : N + 2));
        issue(2'b10, 32'hFFFFFFFF, 32'h2, 6'd12, 1'b1, t1);
        issue(2'b01, 32'h80000000, 32'h80000000, 6'd13, 1'b1, t1);
        issue(2'b00, 32'h80000000, 32'h80000000, 6'd14, 1'b1, t1);
        drain();

        // Result held while the grant is withheld.
        rdy_mode = 2;
        issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 6'd9, 1'b1, t1);
        w = 0;
        @(negedge clk);
        while (!cdb_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("hold_valid_seen", 64'(cdb_valid), 64'(1));
        repeat (5) begin
            @(negedge clk);
            check("hold_avail", 64'(avail), 64'(0));
            check("hold_cdb_valid", 64'(cdb_valid), 64'(1));
        end
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("release_avail", 64'(avail), 64'(1));
        check("release_cdb_valid", 64'(cdb_valid), 64'(0));

        // Flush in BUSY at t+4.
        issue(2'b00, 32'h1234, 32'h5678, 6'd3, 1'b0, t1);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_avail", 64'(avail), 64'(1));
        repeat (12) begin
            @(negedge clk);
            check("flush_no_result", 64'(cdb_valid), 64'(0));
        end
        issue(2'b00, 32'd3, 32'd5, 6'd4, 1'b1, t1);
        drain();

        // Accept with flush, and non-MUL issue, are both dropped.
        @(posedge clk);
        #1;
        valid = 1'b1; fun = FUN_MUL; flush = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_accept_dropped", 64'(avail), 64'(1));
        @(posedge clk);
        #1;
        valid = 1'b1; fun = FUN_DIV;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        check("non_mul_ignored", 64'(avail), 64'(1));

        // Reset mid-operation loses the op.
        issue(2'b01, 32'hDEADBEEF, 32'h5, 6'd7, 1'b0, t1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_avail", 64'(avail), 64'(1));
        check("midreset_cdb_valid", 64'(cdb_valid), 64'(0));

        // Randomized traffic with random grants.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            issue(2'($urandom_range(0, 3)), a, b, 6'($urandom_range(0, 63)), 1'b1, t1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
